// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of a 4-slot TDM link.
// Takes one W-bit slot per valid beat, aligns on the slot-0 sync marker and
// publishes a complete frame as one parallel word. It also reports per-slot
// strobes, lock state and sync protocol errors. All outputs are registered.
module tdm_demux4 #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   din,
   input  logic           din_valid,
   input  logic           sync,
   output logic [4*W-1:0] Y,
   output logic           frame_valid,
   output logic [3:0]     ch_valid,
   output logic [1:0]     slot,
   output logic           locked,
   output logic           sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t         state_q;
   logic [1:0]     slot_q;
   logic [4*W-1:0] y_q;
   logic           frame_valid_q;
   logic [3:0]     ch_valid_q;
   logic           locked_q;
   logic           sync_err_q;

   // Shadow storage for slots 0..2. Slot 3 goes straight from din into Y.
   logic [W-1:0]   shadow_q [3];

   // Qualified beat decodes.
   logic           accept0;    // any valid sync beat is taken as slot 0
   logic           in_locked;
   logic [2:0]     shadow_we;  // per-shadow write enable
   logic           take3;      // last slot: publish the frame
   logic           miss_sync;  // slot 0 expected but no sync seen
   logic           early_sync; // sync arrived before the frame was complete

   // Decode what the current beat does, based on state and slot position.
   always_comb begin
      in_locked    = (state_q == LOCKED);
      accept0      = din_valid && sync;
      shadow_we[0] = accept0;
      shadow_we[1] = din_valid && !sync && in_locked && (slot_q == 2'd1);
      shadow_we[2] = din_valid && !sync && in_locked && (slot_q == 2'd2);
      take3        = din_valid && !sync && in_locked && (slot_q == 2'd3);
      miss_sync    = din_valid && !sync && in_locked && (slot_q == 2'd0);
      early_sync   = accept0 && in_locked && (slot_q != 2'd0);
   end

   // One shadow register per buffered slot. They are never cleared between
   // frames because each slot is always rewritten before Y consumes it.
   for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
      // Capture din into this slot's shadow when the slot is accepted.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            shadow_q[gi] <= '0;
         end else if (shadow_we[gi]) begin
            shadow_q[gi] <= din;
         end
      end
   end

   // Framing FSM: lock tracking, slot counter, strobes, and frame publication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         slot_q        <= 2'd0;
         y_q           <= '0;
         frame_valid_q <= 1'b0;
         ch_valid_q    <= 4'b0000;
         locked_q      <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         // Pulses last one cycle. An idle cycle only clears them.
         frame_valid_q <= 1'b0;
         ch_valid_q    <= 4'b0000;
         sync_err_q    <= early_sync || miss_sync;
         if (din_valid) begin
            if (accept0) begin
               // Slot-0 entry, realignment after an early sync, or a normal start.
               state_q    <= LOCKED;
               locked_q   <= 1'b1;
               slot_q     <= 2'd1;
               ch_valid_q <= 4'b0001;
            end else begin
               case (state_q)
                  HUNT: begin
                     // Unsynchronised beats are dropped while hunting.
                  end
                  LOCKED: begin
                     if (miss_sync) begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                        slot_q   <= 2'd0;
                     end else begin
                        ch_valid_q <= 4'b0001 << slot_q;
                        slot_q     <= slot_q + 2'd1;
                        if (take3) begin
                           y_q           <= {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                           frame_valid_q <= 1'b1;
                        end
                     end
                  end
                  default: begin
                     state_q  <= HUNT;
                     locked_q <= 1'b0;
                     slot_q   <= 2'd0;
                  end
               endcase
            end
         end
      end
   end

   assign Y           = y_q;
   assign frame_valid = frame_valid_q;
   assign ch_valid    = ch_valid_q;
   assign slot        = slot_q;
   assign locked      = locked_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4.
// The driver pushes one expected output snapshot per clock. It takes that
// snapshot from a frame-level model of the TDM protocol. The monitor pops
// one snapshot per clock and compares it with the DUT outputs.
module tb_tdm_demux4;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   din = '0;
   logic           din_valid = 1'b0;
   logic           sync = 1'b0;
   logic [4*W-1:0] Y;
   logic           frame_valid;
   logic [3:0]     ch_valid;
   logic [1:0]     slot;
   logic           locked;
   logic           sync_err;

   always #5 clk = ~clk;

   tdm_demux4 #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .Y           (Y),
      .frame_valid (frame_valid),
      .ch_valid    (ch_valid),
      .slot        (slot),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   typedef struct packed {
      logic [4*W-1:0] y;
      logic           fv;
      logic [3:0]     ch;
      logic [1:0]     sl;
      logic           lk;
      logic           se;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Protocol-level reference: lock flag, next slot, collected slots, frame word.
   bit             m_locked;
   int             m_slot;
   logic [W-1:0]   m_part [4];
   logic [4*W-1:0] m_y;

   function automatic obs_t observed();
      obs_t o;
      o = {Y, frame_valid, ch_valid, slot, locked, sync_err};
      return o;
   endfunction

   task automatic model_reset();
      m_locked = 0;
      m_slot   = 0;
      for (int k = 0; k < 4; k++) m_part[k] = '0;
      m_y = '0;
   endtask

   // Drive one clock's worth of inputs and queue the expected result.
   task automatic beat(input bit rst_act, input bit v, input bit s, input logic [W-1:0] d);
      obs_t e;
      obs_t a;
      if (rst_act && rst_n) begin
         rst_n = 1'b0;
         #1;
         a = observed();
         checks++;
         if (a !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h required=0", a);
         end
      end
      rst_n     = ~rst_act;
      din       = d;
      din_valid = v;
      sync      = s;
      e = '0;
      if (rst_act) begin
         model_reset();
      end else if (v) begin
         if (s) begin
            // A sync beat always starts a new frame. If it arrives mid-frame,
            // the partial frame is dropped and the error is flagged.
            if (m_locked && m_slot != 0) e.se = 1'b1;
            m_part[0] = d;
            e.ch      = 4'b0001;
            m_slot    = 1;
            m_locked  = 1;
         end else if (m_locked) begin
            if (m_slot == 0) begin
               e.se     = 1'b1;
               m_locked = 0;
            end else begin
               m_part[m_slot] = d;
               e.ch[m_slot]   = 1'b1;
               if (m_slot == 3) begin
                  for (int k = 0; k < 4; k++) m_y[k*W +: W] = m_part[k];
                  e.fv = 1'b1;
               end
               m_slot = (m_slot + 1) % 4;
            end
         end
      end
      e.y  = m_y;
      e.sl = 2'(m_slot);
      e.lk = m_locked;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic frame(input logic [W-1:0] d0, d1, d2, d3, input int gap);
      beat(0, 1, 1, d0); repeat (gap) beat(0, 0, 0, 4'hF);
      beat(0, 1, 0, d1); repeat (gap) beat(0, 0, 1, 4'hF);
      beat(0, 1, 0, d2); repeat (gap) beat(0, 0, 0, 4'hF);
      beat(0, 1, 0, d3); repeat (gap) beat(0, 0, 1, 4'hF);
   endtask

   // Monitor: once per clock, compare the DUT outputs with the oldest expectation.
   initial begin
      obs_t e;
      obs_t a;
      forever begin
         @(posedge clk);
         #1;
         a = observed();
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow t=%0t got=%h required=queued expectation", $time, a);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got Y=%h fv=%b ch=%b slot=%0d lk=%b se=%b required Y=%h fv=%b ch=%b slot=%0d lk=%b se=%b",
                        $time, a.y, a.fv, a.ch, a.sl, a.lk, a.se, e.y, e.fv, e.ch, e.sl, e.lk, e.se);
            end else if (a.fv) begin
               $display("frame t=%0t Y=%h", $time, a.y);
            end
         end
      end
   end

   initial begin
      bit s;
      model_reset();
      beat(1, 0, 0, 0); beat(1, 1, 1, 4'h3);
      // Basic frame.
      frame(4'h1, 4'h2, 4'h3, 4'h4, 0);
      beat(0, 0, 0, 0);
      // Hunting: unsynced beats are ignored.
      beat(1, 0, 0, 0);
      beat(0, 1, 0, 4'h7); beat(0, 1, 0, 4'h8);
      frame(4'hA, 4'hB, 4'hC, 4'hD, 0);
      // Early sync realign.
      beat(1, 0, 0, 0);
      frame(4'h1, 4'h2, 4'h3, 4'h4, 0);
      beat(0, 1, 1, 4'h5); beat(0, 1, 0, 4'h6);
      frame(4'h9, 4'hA, 4'hB, 4'hC, 0);
      // Missing sync at slot 0.
      beat(0, 1, 0, 4'hE); beat(0, 0, 0, 0);
      // Idle gaps between beats.
      beat(1, 0, 0, 0);
      frame(4'h1, 4'h2, 4'h3, 4'h4, 2);
      // Asynchronous reset mid-frame.
      beat(0, 1, 1, 4'h1); beat(0, 1, 0, 4'h2);
      beat(1, 1, 0, 4'h3); beat(1, 0, 0, 0);
      frame(4'h5, 4'h6, 4'h7, 4'h8, 0);
      // Randomised traffic, mostly well-formed with occasional violations.
      for (int i = 0; i < 600; i++) begin
         s = (m_slot == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
         beat($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, s, W'($urandom));
      end
      beat(0, 0, 0, 0); beat(0, 0, 0, 0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d entries required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
